eth_rx_frame_fetcher: RTL
=========================

ETH_RX_FRAME_FETCHER -- requirements
Module: eth_rx_frame_fetcher

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, base address of the MAC MMIO register window.
REQ-002 Parameter MAX_WORDS, default 1024, local frame buffer depth in 32-bit words (power of 2, 16..4096).
REQ-003 Parameter POLL_LIMIT, default 1000, number of consecutive RX_VALID=0 polls before timeout.
REQ-004 clk  in  1  system clock; all logic single-domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins fetching one frame; ignored while busy=1.
REQ-007 busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-008 done  out  1  one-cycle pulse at frame end or abort.
REQ-009 frame_len  out  16  bytes written to buffer for the last frame; stable from done until the next accepted start.
REQ-010 err_overflow / err_timeout  out  1 each  status for the last frame; valid with done, held until the next accepted start.
REQ-011 wr_en / wr_addr / wr_data  out  1 / log2(MAX_WORDS) / 32  buffer write port, one word per wr_en cycle.
REQ-012 strobe_o  out  1  MMIO request, one-cycle pulse.
REQ-013 addr_o / we_o / data_o  out  32 / 1 / 32  MMIO request address, write flag (always 0), write data (always 0).
REQ-014 done_i / data_i  in  1 / 32  MMIO completion pulse and read data (data_i valid in the done_i cycle).

Function
REQ-015 Only one MMIO transaction outstanding; strobe_o is never asserted while awaiting done_i.
REQ-016 MMIO offsets: RX_DATA 0x00, RX_KEEP 0x04, RX_VALID 0x08, RX_LAST 0x0C; addr_o = BASE_ADDR + offset.
REQ-017 addr_o holds its value from the strobe_o cycle until done_i arrives.
REQ-018 States: IDLE, POLL, KEEP, LAST, DATA, FIN; each non-IDLE/FIN state issues one read, then waits for done_i.
REQ-019 IDLE -> POLL on start; clears frame_len, word counter, poll counter, error flags.
REQ-020 POLL: read RX_VALID; data_i[0]=1 -> KEEP, poll counter cleared; data_i[0]=0 -> poll counter+1, reissue POLL; counter reaching POLL_LIMIT -> FIN with err_timeout=1.
REQ-021 KEEP: read RX_KEEP, latch data_i[3:0] -> LAST; LAST: read RX_LAST, latch data_i[0] -> DATA.
REQ-022 DATA: read RX_DATA (this read pops the MAC word); KEEP and LAST are always read before DATA for the same word.
REQ-023 On DATA done_i with word counter < MAX_WORDS: wr_en=1 for exactly that cycle, wr_addr=word counter, wr_data=data_i; word counter+1; frame_len += popcount(keep), saturating at 16'hFFFF.
REQ-024 On DATA done_i with word counter = MAX_WORDS: no write, err_overflow=1, frame_len unchanged; the word is still consumed.
REQ-025 After DATA: latched last=1 -> FIN; last=0 -> POLL (timeout applies mid-frame too).
REQ-026 FIN: done=1 for one cycle, busy=0 the same cycle -> IDLE.
REQ-027 start is accepted only in IDLE; a start coinciding with done is ignored.
REQ-028 done_i arriving in IDLE or FIN is ignored.
REQ-029 MMIO round-trip latency is arbitrary (>=1 cycle); no internal done_i timeout.

Reset
REQ-030 During rst: state=IDLE, strobe_o=0, addr_o=0, busy=0, done=0, wr_en=0, frame_len=0, error flags=0, all counters=0.
REQ-031 rst mid-transaction aborts immediately; no done pulse; a done_i arriving after reset release is ignored (REQ-028).

Verification
REQ-032 Start; slave returns VALID=1, 16 words, keep=4'hF, LAST on word 16 -> 16 wr_en pulses, wr_addr 0..15, frame_len=64, done once, no errors.
REQ-033 Frame of 15 words keep=4'hF + final word keep=4'h3 -> frame_len=62, 16 writes.
REQ-034 POLL_LIMIT=5, RX_VALID always 0 -> exactly 5 RX_VALID reads, done with err_timeout=1, frame_len=0, no RX_DATA read.
REQ-035 MAX_WORDS=16, 20-word frame -> 16 writes, 20 RX_DATA reads, err_overflow=1, frame_len=64.
REQ-036 Slave done_i latency varied 1..7 cycles per transaction -> strobe_o never asserted while awaiting done_i; per-word read order VALID, KEEP, LAST, DATA.
REQ-037 rst asserted while awaiting DATA done_i -> all outputs at reset values next cycle; late done_i ignored; next start fetches normally.

Source files
------------

// File: rtl/eth_rx_frame_fetcher_if.sv
// eth_rx_frame_fetcher_if: single-outstanding MMIO read bus between the fetcher and the MAC register window
interface eth_rx_frame_fetcher_if;
    logic        strobe_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] data_o;
    logic        done_i;
    logic [31:0] data_i;
    modport master (output strobe_o, addr_o, we_o, data_o, input done_i, data_i);
    modport slave (input strobe_o, addr_o, we_o, data_o, output done_i, data_i);
endinterface

// File: rtl/eth_rx_frame_fetcher.sv
// eth_rx_frame_fetcher: polls a MAC RX MMIO window and copies one frame into a local word buffer
module eth_rx_frame_fetcher #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024,
    parameter int          POLL_LIMIT = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  frame_len,
    output logic                         err_overflow,
    output logic                         err_timeout,
    output logic                         wr_en,
    output logic [$clog2(MAX_WORDS)-1:0] wr_addr,
    output logic [31:0]                  wr_data,
    eth_rx_frame_fetcher_if.master       mmio
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    typedef enum logic [2:0] {IDLE, POLL, KEEP, LAST, DATA, FIN} state_t;
    state_t state, state_n;
    logic pend, ack, rd, room, last_q, poll_exp;
    logic [3:0] keep_q;
    logic [AW:0] word_cnt;
    logic [PW-1:0] poll_cnt;
    logic [16:0] len_sum;
    assign rd = state inside {POLL, KEEP, LAST, DATA};
    // pend marks an issued read whose done_i is still due; it keeps strobe_o quiet meanwhile
    assign ack = pend && mmio.done_i;
    assign room = word_cnt < (AW + 1)'(MAX_WORDS);
    assign poll_exp = poll_cnt == PW'(POLL_LIMIT - 1);
    assign len_sum = {1'b0, frame_len} + 17'($countones(keep_q));
    assign mmio.strobe_o = !rst && rd && !pend;
    assign mmio.addr_o = (rst || !rd) ? '0 : BASE_ADDR + ((state == POLL) ? 32'h8 : (state == KEEP) ? 32'h4 : (state == LAST) ? 32'hC : 32'h0);
    assign mmio.we_o = 1'b0;
    assign mmio.data_o = '0;
    assign wr_addr = word_cnt[AW-1:0];
    assign wr_data = mmio.data_i;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        busy = !rst && state != IDLE && state != FIN;
        done = !rst && state == FIN;
        wr_en = !rst && state == DATA && ack && room;
        case (state)
            IDLE: state_n = start ? POLL : IDLE;
            POLL: if (ack) state_n = mmio.data_i[0] ? KEEP : poll_exp ? FIN : POLL;
            KEEP: if (ack) state_n = LAST;
            LAST: if (ack) state_n = DATA;
            DATA: if (ack) state_n = last_q ? FIN : POLL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            frame_len <= '0;
            err_overflow <= 1'b0;
            err_timeout <= 1'b0;
            word_cnt <= '0;
            poll_cnt <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            if (mmio.strobe_o) pend <= 1'b1;
            else if (ack) pend <= 1'b0;
            if (state == IDLE && start) begin
                frame_len <= '0;
                err_overflow <= 1'b0;
                err_timeout <= 1'b0;
                word_cnt <= '0;
                poll_cnt <= '0;
            end
            if (ack) begin
                case (state)
                    POLL: begin
                        poll_cnt <= mmio.data_i[0] ? '0 : poll_cnt + 1'b1;
                        if (!mmio.data_i[0] && poll_exp) err_timeout <= 1'b1;
                    end
                    KEEP: keep_q <= mmio.data_i[3:0];
                    LAST: last_q <= mmio.data_i[0];
                    DATA: begin
                        // a full buffer still consumes the MAC word, it just is not stored
                        if (room) begin
                            word_cnt <= word_cnt + 1'b1;
                            frame_len <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
                        end else err_overflow <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
